// File: rtl/cnt_window_sequencer_pkg.sv
// Shared definitions for the counter window sequencer: FSM states, counter
// direction codes and program-entry field layout {laps, mode, max, min}.
package cnt_window_sequencer_pkg;

   localparam int unsigned CNT_W      = 4;
   localparam int unsigned PROG_DEPTH = 4;
   localparam int unsigned LAP_W      = 4;

   localparam logic MODE_UP = 1'b0;
   localparam logic MODE_DN = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } seq_state_e;

   function automatic int unsigned entry_width(input int unsigned w, input int unsigned lapw);
      return lapw + 1 + 2 * w;
   endfunction

   function automatic int unsigned mode_bit(input int unsigned w);
      return 2 * w;
   endfunction

   function automatic int unsigned laps_lsb(input int unsigned w);
      return 2 * w + 1;
   endfunction

endpackage

// File: rtl/cnt_window_sequencer_if.sv
// Bundle between the control/config side and the sequencer, including the
// counter control outputs and its OUT feedback.
interface cnt_window_sequencer_if import cnt_window_sequencer_pkg::*; #(
   parameter int unsigned W     = CNT_W,
   parameter int unsigned DEPTH = PROG_DEPTH,
   parameter int unsigned LAPW  = LAP_W
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned EW = entry_width(W, LAPW);

   logic          start;
   logic          hold;
   logic          abort;
   logic          loop_en;
   logic [AW:0]   n_entries;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [EW-1:0] prog_data;
   logic [W-1:0]  cnt_out;
   logic          cnt_rst;
   logic          cnt_ss;
   logic          cnt_mode;
   logic [W-1:0]  cnt_min;
   logic [W-1:0]  cnt_max;
   logic [AW-1:0] entry_idx;
   logic          busy;
   logic          done;
   logic          err;

   modport master (
      output start, hold, abort, loop_en, n_entries, prog_we, prog_addr, prog_data, cnt_out,
      input  cnt_rst, cnt_ss, cnt_mode, cnt_min, cnt_max, entry_idx, busy, done, err
   );

   modport slave (
      input  start, hold, abort, loop_en, n_entries, prog_we, prog_addr, prog_data, cnt_out,
      output cnt_rst, cnt_ss, cnt_mode, cnt_min, cnt_max, entry_idx, busy, done, err
   );

endinterface

// File: rtl/cnt_window_sequencer_prog_table.sv
// Program table: DEPTH entries, synchronous write, combinational read,
// cleared asynchronously by the active-low reset.
module cnt_window_sequencer_prog_table #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned EW    = 13,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [EW-1:0] data_i,
   input  logic [AW-1:0] raddr_i,
   output logic [EW-1:0] rdata_o
);

   logic [EW-1:0] table_q [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            table_q[i] <= '0;
         end
      end else if (we_i) begin
         table_q[addr_i] <= data_i;
      end
   end

   assign rdata_o = table_q[raddr_i];

endmodule

// File: rtl/cnt_window_sequencer.sv
// Steps a bounded up/down counter through programmed windows, running each
// window for a number of full laps, then advancing, looping or finishing.
module cnt_window_sequencer import cnt_window_sequencer_pkg::*; #(
   parameter int unsigned W     = CNT_W,
   parameter int unsigned DEPTH = PROG_DEPTH,
   parameter int unsigned LAPW  = LAP_W
) (
   input  logic                   clk,
   input  logic                   rst,
   cnt_window_sequencer_if.slave  seq_if
);

   localparam int unsigned AW     = $clog2(DEPTH);
   localparam int unsigned NW     = AW + 1;
   localparam int unsigned EW     = entry_width(W, LAPW);
   localparam int unsigned MODE_B = mode_bit(W);
   localparam int unsigned LAPS_L = laps_lsb(W);

   seq_state_e    state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [LAPW-1:0] lap_q, lap_d, laps_q, laps_d;
   logic [W-1:0]  min_q, min_d, max_q, max_d, end_val;
   logic          mode_q, mode_d;
   logic [EW-1:0] rd_data;
   logic [NW-1:0] n_eff;
   logic          is_last, entry_valid, run_en, lap_hit, advance, load;

   // The table is read at the next index so the entry is latched on entry to LOAD.
   cnt_window_sequencer_prog_table #(.DEPTH(DEPTH), .EW(EW), .AW(AW)) u_table (
      .clk     (clk),
      .rst     (rst),
      .we_i    (seq_if.prog_we && (state_q == S_IDLE)),
      .addr_i  (seq_if.prog_addr),
      .data_i  (seq_if.prog_data),
      .raddr_i (idx_d),
      .rdata_o (rd_data)
   );

   always_comb begin
      n_eff = seq_if.n_entries;
      if (seq_if.n_entries == '0) begin
         n_eff = NW'(1);
      end else if (seq_if.n_entries > NW'(DEPTH)) begin
         n_eff = NW'(DEPTH);
      end
      end_val = max_q;
      case (mode_q)
         MODE_UP: end_val = max_q;
         MODE_DN: end_val = min_q;
         default: end_val = max_q;
      endcase
   end

   assign is_last     = ({1'b0, idx_q} == (n_eff - NW'(1)));
   assign entry_valid = (laps_q != '0) && (min_q <= max_q);
   assign run_en      = (state_q == S_RUN) && !seq_if.hold;
   assign lap_hit     = run_en && (seq_if.cnt_out == end_val);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      lap_d   = lap_q;
      advance = 1'b0;
      load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (seq_if.start) begin
               state_d = S_LOAD;
               idx_d   = '0;
               load    = 1'b1;
            end
         end
         S_LOAD: begin
            lap_d = '0;
            if (entry_valid) state_d = S_RUN;
            else             advance = 1'b1;
         end
         S_RUN: begin
            if (lap_hit) begin
               if (lap_q == laps_q - LAPW'(1)) advance = 1'b1;
               else                            lap_d   = lap_q + LAPW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (advance) begin
         if (!is_last) begin
            idx_d   = idx_q + AW'(1);
            state_d = S_LOAD;
            load    = 1'b1;
         end else if (seq_if.loop_en) begin
            idx_d   = '0;
            state_d = S_LOAD;
            load    = 1'b1;
         end else begin
            state_d = S_DONE;
         end
      end
      // Abort dominates everything, including a simultaneous start.
      if (seq_if.abort) begin
         state_d = S_IDLE;
         idx_d   = idx_q;
         load    = 1'b0;
      end
   end

   always_comb begin
      min_d  = min_q;
      max_d  = max_q;
      mode_d = mode_q;
      laps_d = laps_q;
      if (load) begin
         min_d  = rd_data[W-1:0];
         max_d  = rd_data[2*W-1:W];
         mode_d = rd_data[MODE_B];
         laps_d = rd_data[EW-1:LAPS_L];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         lap_q   <= '0;
         laps_q  <= '0;
         min_q   <= '0;
         max_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         lap_q   <= lap_d;
         laps_q  <= laps_d;
         min_q   <= min_d;
         max_q   <= max_d;
         mode_q  <= mode_d;
      end
   end

   assign seq_if.cnt_ss    = run_en;
   assign seq_if.cnt_rst   = (state_q == S_LOAD) && entry_valid;
   assign seq_if.err       = (state_q == S_LOAD) && !entry_valid;
   assign seq_if.busy      = (state_q == S_LOAD) || (state_q == S_RUN);
   assign seq_if.done      = (state_q == S_DONE);
   assign seq_if.entry_idx = idx_q;
   assign seq_if.cnt_min   = min_q;
   assign seq_if.cnt_max   = max_q;
   assign seq_if.cnt_mode  = mode_q;

endmodule
